alu_issue_unit: RTL and testbench

Sequencing stage that sits directly upstream of the ALU and consumes its results. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU operand/control inputs, evaluates an ARM-style condition code against stored NZCV flags, then writes the result back and updates the flags. It also owns the carry fed back into the ALU `CI` input.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_issue_unit_cond_check.sv | 34 +++
 rtl/alu_issue_unit.sv | 218 +++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, condition codes,
// FSM encoding and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_UD8 = 4'h8;
  localparam logic [3:0] OP_UD9 = 4'h9;
  localparam logic [3:0] OP_UDA = 4'hA;
  localparam logic [3:0] OP_UDB = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Arithmetic ops are the only ones whose carry/overflow are meaningful.
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= OP_SUB) && (op <= OP_RSC);
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    return op[3:2] != 2'b10;
  endfunction

endpackage

// File: rtl/alu_issue_unit_cond_check.sv
// Combinational ARM-style condition evaluation against the NZCV flags.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_CS: pass = c;
      CC_CC: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Three-cycle issue stage (IDLE/EXEC/WB) wrapped around an external ALU:
// owns the register file, the NZCV flags and the ALU carry-in.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 8,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [3:0]       instr_cond,
  input  logic             instr_s,
  input  logic             instr_wb,
  input  logic             instr_imm_en,
  input  logic [RW-1:0]    instr_rd,
  input  logic [RW-1:0]    instr_rn,
  input  logic [RW-1:0]    instr_rm,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [3:0]       alu_control,
  output logic             alu_ci,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co,
  input  logic             alu_ovf,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             res_valid,
  output logic             res_exec,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  input  logic [RW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d, cond_q, cond_d;
  logic             s_q, s_d, wb_q, wb_d, imm_en_q, imm_en_d;
  logic [RW-1:0]    rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_exec_q, res_exec_d;
  logic             res_n_q, res_n_d, res_z_q, res_z_d;
  logic             res_c_q, res_c_d, res_v_q, res_v_d;
  logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d, flag_v_q, flag_v_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic [3:0]       ctl_hold_q, ctl_hold_d;
  logic             ci_hold_q, ci_hold_d;
  logic [WIDTH-1:0] live_a, live_b;
  logic             in_exec, cond_pass;

  cond_check u_cond_check (
    .cond (cond_q),
    .n    (flag_n_q),
    .z    (flag_z_q),
    .c    (flag_c_q),
    .v    (flag_v_q),
    .pass (cond_pass)
  );

  // The ALU sees live operands only in EXEC and a frozen copy otherwise.
  assign in_exec     = (state_q == ST_EXEC);
  assign live_a      = regs_q[rn_q];
  assign live_b      = imm_en_q ? imm_q : regs_q[rm_q];
  assign alu_a       = in_exec ? live_a   : a_hold_q;
  assign alu_b       = in_exec ? live_b   : b_hold_q;
  assign alu_control = in_exec ? op_q     : ctl_hold_q;
  assign alu_ci      = in_exec ? flag_c_q : ci_hold_q;

  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_WB);
  assign res_exec    = res_exec_q;
  assign res_data    = res_data_q;
  assign flag_n      = flag_n_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign flag_v      = flag_v_q;
  assign dbg_data    = regs_q[dbg_addr];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cond_d     = cond_q;
    s_d        = s_q;
    wb_d       = wb_q;
    imm_en_d   = imm_en_q;
    rd_d       = rd_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    imm_d      = imm_q;
    regs_d     = regs_q;
    res_data_d = res_data_q;
    res_exec_d = res_exec_q;
    res_n_d    = res_n_q;
    res_z_d    = res_z_q;
    res_c_d    = res_c_q;
    res_v_d    = res_v_q;
    flag_n_d   = flag_n_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    flag_v_d   = flag_v_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    ctl_hold_d = ctl_hold_q;
    ci_hold_d  = ci_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d     = instr_op;
          cond_d   = instr_cond;
          s_d      = instr_s;
          wb_d     = instr_wb;
          imm_en_d = instr_imm_en;
          rd_d     = instr_rd;
          rn_d     = instr_rn;
          rm_d     = instr_rm;
          imm_d    = instr_imm;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d = alu_out;
        res_exec_d = cond_pass & is_defined(op_q);
        res_n_d    = alu_n;
        res_z_d    = alu_z;
        res_c_d    = alu_co;
        res_v_d    = alu_ovf;
        a_hold_d   = live_a;
        b_hold_d   = live_b;
        ctl_hold_d = op_q;
        ci_hold_d  = flag_c_q;
        state_d    = ST_WB;
      end
      ST_WB: begin
        if (res_exec_q) begin
          if (wb_q) regs_d[rd_q] = res_data_q;
          if (s_q) begin
            flag_n_d = res_n_q;
            flag_z_d = res_z_q;
            if (is_arith(op_q)) begin
              flag_c_d = res_c_q;
              flag_v_d = res_v_q;
            end
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cond_q     <= '0;
      s_q        <= 1'b0;
      wb_q       <= 1'b0;
      imm_en_q   <= 1'b0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      res_data_q <= '0;
      res_exec_q <= 1'b0;
      res_n_q    <= 1'b0;
      res_z_q    <= 1'b0;
      res_c_q    <= 1'b0;
      res_v_q    <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      ctl_hold_q <= '0;
      ci_hold_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cond_q     <= cond_d;
      s_q        <= s_d;
      wb_q       <= wb_d;
      imm_en_q   <= imm_en_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      imm_q      <= imm_d;
      regs_q     <= regs_d;
      res_data_q <= res_data_d;
      res_exec_q <= res_exec_d;
      res_n_q    <= res_n_d;
      res_z_q    <= res_z_d;
      res_c_q    <= res_c_d;
      res_v_q    <= res_v_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      flag_v_q   <= flag_v_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      ctl_hold_q <= ctl_hold_d;
      ci_hold_q  <= ci_hold_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU closing the loop.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, instr_ready;
  logic [3:0] instr_op, instr_cond;
  logic       instr_s, instr_wb, instr_imm_en;
  logic [2:0] instr_rd, instr_rn, instr_rm;
  logic [7:0] instr_imm;
  logic [3:0] alu_control;
  logic       alu_ci;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_co, alu_ovf, alu_n, alu_z;
  logic       res_valid, res_exec;
  logic [7:0] res_data;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.WIDTH(8), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_cond(instr_cond), .instr_s(instr_s),
    .instr_wb(instr_wb), .instr_imm_en(instr_imm_en),
    .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
    .instr_imm(instr_imm),
    .alu_control(alu_control), .alu_ci(alu_ci), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .alu_n(alu_n), .alu_z(alu_z),
    .res_valid(res_valid), .res_exec(res_exec), .res_data(res_data),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU; logic ops report co=0/ovf=1 so a wrongful C/V update shows.
  logic [7:0] m_x, m_y, m_out;
  logic       m_cin, m_arith;
  logic [8:0] m_sum;
  always_comb begin
    m_x = '0; m_y = '0; m_cin = 1'b0; m_arith = 1'b1; m_out = '0;
    case (alu_control)
      4'h0: begin m_arith = 1'b0; m_out = alu_a & alu_b; end
      4'h1: begin m_arith = 1'b0; m_out = alu_a ^ alu_b; end
      4'h2: begin m_x = alu_a; m_y = ~alu_b; m_cin = 1'b1;   end
      4'h3: begin m_x = alu_b; m_y = ~alu_a; m_cin = 1'b1;   end
      4'h4: begin m_x = alu_a; m_y = alu_b;  m_cin = 1'b0;   end
      4'h5: begin m_x = alu_a; m_y = alu_b;  m_cin = alu_ci; end
      4'h6: begin m_x = alu_a; m_y = ~alu_b; m_cin = alu_ci; end
      4'h7: begin m_x = alu_b; m_y = ~alu_a; m_cin = alu_ci; end
      4'hC: begin m_arith = 1'b0; m_out = alu_a | alu_b;  end
      4'hD: begin m_arith = 1'b0; m_out = alu_b;          end
      4'hE: begin m_arith = 1'b0; m_out = alu_a & ~alu_b; end
      4'hF: begin m_arith = 1'b0; m_out = ~alu_b;         end
      default: begin m_arith = 1'b0; m_out = ~alu_a; end
    endcase
    m_sum = {1'b0, m_x} + {1'b0, m_y} + {8'b0, m_cin};
    if (m_arith) m_out = m_sum[7:0];
    alu_out = m_out;
    alu_co  = m_arith ? m_sum[8] : 1'b0;
    alu_ovf = m_arith ? ((m_x[7] == m_y[7]) && (m_sum[7] != m_x[7])) : 1'b1;
    alu_n   = m_out[7];
    alu_z   = (m_out == 8'h00);
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] cond,
                       input logic s, input logic wb, input logic ie,
                       input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [7:0] imm,
                       output logic v_exec, output logic v_wb,
                       output logic v_after, output logic x_exec,
                       output logic [7:0] x_data, output logic [7:0] d_wb,
                       output logic [7:0] d_after);
    int n;
    n = 0;
    instr_op = op; instr_cond = cond; instr_s = s; instr_wb = wb;
    instr_imm_en = ie; instr_rd = rd; instr_rn = rn; instr_rm = rm;
    instr_imm = imm; dbg_addr = rd; instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 10) begin
      n_checks++; n_fails++;
      $display("FAIL accept_timeout: instr_ready stayed %b, required 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    v_exec = res_valid;
    @(posedge clk); #1;
    v_wb = res_valid; x_exec = res_exec; x_data = res_data; d_wb = dbg_data;
    @(posedge clk); #1;
    v_after = res_valid; d_after = dbg_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_cond = '0;
    instr_s = 0; instr_wb = 0; instr_imm_en = 0; instr_rd = '0;
    instr_rn = '0; instr_rm = '0; instr_imm = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (instr_ready !== 1'b1) begin n_fails++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    n_checks++; if ({res_valid, res_exec} !== 2'b00) begin n_fails++; $display("FAIL rst_res: got %b want 00", {res_valid, res_exec}); end
    n_checks++; if (res_data !== 8'h00) begin n_fails++; $display("FAIL rst_data: got %h want 00", res_data); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin n_fails++; $display("FAIL rst_flags: got %b want 0000", {flag_n, flag_z, flag_c, flag_v}); end
    n_checks++; if ({alu_control, alu_ci, alu_a, alu_b} !== 21'h0) begin n_fails++; $display("FAIL rst_alu: got %h want 0", {alu_control, alu_ci, alu_a, alu_b}); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      n_checks++; if (dbg_data !== 8'h00) begin n_fails++; $display("FAIL rst_reg%0d: got %h want 00", i, dbg_data); end
    end
  endtask

  task automatic test_mov();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    issue(4'hD, 4'hE, 1, 1, 1, 3'd1, 3'd0, 3'd0, 8'h7F, ve, vw, va, xe, xd, dw, da);
    n_checks++; if ({ve, vw, va} !== 3'b010) begin n_fails++; $display("FAIL mov_valid_pulse: got %b want 010", {ve, vw, va}); end
    n_checks++; if (xe !== 1'b1) begin n_fails++; $display("FAIL mov_exec: got %b want 1", xe); end
    n_checks++; if (xd !== 8'h7F) begin n_fails++; $display("FAIL mov_data: got %h want 7f", xd); end
    n_checks++; if (dw !== 8'h00) begin n_fails++; $display("FAIL mov_dbg_prewrite: got %h want 00", dw); end
    n_checks++; if (da !== 8'h7F) begin n_fails++; $display("FAIL mov_r1: got %h want 7f", da); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin n_fails++; $display("FAIL mov_flags: got %b want 0000", {flag_n, flag_z, flag_c, flag_v}); end
  endtask

  task automatic test_add();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    issue(4'h4, 4'hE, 1, 1, 1, 3'd2, 3'd1, 3'd0, 8'h01, ve, vw, va, xe, xd, dw, da);
    n_checks++; if (da !== 8'h80) begin n_fails++; $display("FAIL add_r2: got %h want 80", da); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1001) begin n_fails++; $display("FAIL add_flags: got %b want 1001", {flag_n, flag_z, flag_c, flag_v}); end
  endtask

  // Flags are N=1 Z=0 C=0 V=1 here; bit k of want is the outcome for cond k.
  task automatic test_cond_table();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    logic [15:0] want;
    want = 16'hD65A;
    for (int k = 0; k < 16; k++) begin
      issue(4'hD, 4'(k), 0, 0, 1, 3'd7, 3'd0, 3'd0, 8'h3C, ve, vw, va, xe, xd, dw, da);
      n_checks++; if (xe !== want[k]) begin n_fails++; $display("FAIL cond_%0d: res_exec %b want %b", k, xe, want[k]); end
    end
    dbg_addr = 3'd7; #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_fails++; $display("FAIL cond_nowrite_r7: got %h want 00", dbg_data); end
  endtask

  task automatic test_sub_cond();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    issue(4'h2, 4'hE, 1, 0, 0, 3'd2, 3'd2, 3'd2, 8'h00, ve, vw, va, xe, xd, dw, da);
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin n_fails++; $display("FAIL sub_flags: got %b want 0110", {flag_n, flag_z, flag_c, flag_v}); end
    n_checks++; if (da !== 8'h80) begin n_fails++; $display("FAIL sub_r2_kept: got %h want 80", da); end
    issue(4'hD, 4'h0, 0, 1, 1, 3'd3, 3'd0, 3'd0, 8'h55, ve, vw, va, xe, xd, dw, da);
    n_checks++; if ({xe, da} !== {1'b1, 8'h55}) begin n_fails++; $display("FAIL moveq: exec,r3 got %b,%h want 1,55", xe, da); end
    issue(4'hD, 4'h1, 0, 1, 1, 3'd4, 3'd0, 3'd0, 8'hAA, ve, vw, va, xe, xd, dw, da);
    n_checks++; if ({xe, da} !== {1'b0, 8'h00}) begin n_fails++; $display("FAIL movne: exec,r4 got %b,%h want 0,00", xe, da); end
  endtask

  task automatic test_adc_and();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    issue(4'hD, 4'hE, 0, 1, 1, 3'd5, 3'd0, 3'd0, 8'h01, ve, vw, va, xe, xd, dw, da);
    issue(4'h5, 4'hE, 0, 1, 1, 3'd5, 3'd5, 3'd0, 8'h01, ve, vw, va, xe, xd, dw, da);
    n_checks++; if (da !== 8'h03) begin n_fails++; $display("FAIL adc_r5: got %h want 03", da); end
    issue(4'h0, 4'hE, 1, 0, 1, 3'd5, 3'd5, 3'd0, 8'h00, ve, vw, va, xe, xd, dw, da);
    n_checks++; if (xd !== 8'h00) begin n_fails++; $display("FAIL and_data: got %h want 00", xd); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin n_fails++; $display("FAIL and_flags: got %b want 0110", {flag_n, flag_z, flag_c, flag_v}); end
  endtask

  task automatic test_undef();
    logic ve, vw, va, xe; logic [7:0] xd, dw, da;
    issue(4'h8, 4'hE, 1, 1, 1, 3'd7, 3'd5, 3'd0, 8'h00, ve, vw, va, xe, xd, dw, da);
    n_checks++; if ({vw, xe} !== 2'b10) begin n_fails++; $display("FAIL undef_exec: valid,exec got %b want 10", {vw, xe}); end
    n_checks++; if (da !== 8'h00) begin n_fails++; $display("FAIL undef_r7: got %h want 00", da); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin n_fails++; $display("FAIL undef_flags: got %b want 0110", {flag_n, flag_z, flag_c, flag_v}); end
  endtask

  task automatic test_back_to_back();
    int acc, vcnt;
    acc = 0; vcnt = 0;
    instr_op = 4'hD; instr_cond = 4'hE; instr_s = 0; instr_wb = 0;
    instr_imm_en = 1; instr_rd = 3'd0; instr_imm = 8'h99; instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (instr_ready && instr_valid) acc++;
      @(posedge clk); #1;
      if (res_valid) vcnt++;
    end
    instr_valid = 1'b0;
    n_checks++; if (acc != 3) begin n_fails++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    n_checks++; if (vcnt != 3) begin n_fails++; $display("FAIL b2b_res_valid: got %0d want 3", vcnt); end
  endtask

  task automatic test_reset_in_exec();
    instr_op = 4'hD; instr_cond = 4'hE; instr_s = 1; instr_wb = 1;
    instr_imm_en = 1; instr_rd = 3'd6; instr_imm = 8'h11; instr_valid = 1'b1;
    dbg_addr = 3'd6;
    n_checks++; if (instr_ready !== 1'b1) begin n_fails++; $display("FAIL rexec_pre_ready: got %b want 1", instr_ready); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if ({instr_ready, res_valid} !== 2'b10) begin n_fails++; $display("FAIL rexec_state: ready,valid got %b want 10", {instr_ready, res_valid}); end
    @(posedge clk); #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_fails++; $display("FAIL rexec_r6: got %h want 00", dbg_data); end
    dbg_addr = 3'd1; #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_fails++; $display("FAIL rexec_r1_cleared: got %h want 00", dbg_data); end
    n_checks++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin n_fails++; $display("FAIL rexec_flags: got %b want 0000", {flag_n, flag_z, flag_c, flag_v}); end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add();
    test_cond_table();
    test_sub_cond();
    test_adc_and();
    test_undef();
    test_back_to_back();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
